add_sequencer: RTL and testbench
================================

// Module: add_sequencer
// PURPOSE
//   Owns a NREG x WIDTH register file and sequences the shared combinational
//   32-bit adder (module add) over it.
//   Each run executes COUNT iterations of: x[rd] = x[rs1] + x[rs2]; x[rs2] = x[rd].
//   This is the feedback accumulate loop used with the adder (x[5] = x[6] + x[7], x[7] <- x[5]).
//   It sits between the host load/read ports and the external adder instance.
// PARAMETERS
//   WIDTH  32  data width of registers and adder operands
//   NREG   32  number of registers in the file
//   AW     5   register address width, AW = clog2(NREG)
// PORTS
//   clk      in   1      clock, all state updates on rising edge
//   reset    in   1      asynchronous, active-high; clears all state
//   start    in   1      request a run; sampled only in IDLE
//   rd       in   AW     destination register index, latched at start
//   rs1      in   AW     operand A register index, latched at start
//   rs2      in   AW     operand B / feedback register index, latched at start
//   count    in   8      iteration count, latched at start
//   ld_en    in   1      host write enable; honoured only in IDLE
//   ld_addr  in   AW     host write index
//   ld_data  in   WIDTH  host write data
//   rd_addr  in   AW     host read index
//   rd_data  out  WIDTH  x[rd_addr], combinational, valid in every state
//   add_a    out  WIDTH  operand A to the adder (latched register, glitch-free)
//   add_b    out  WIDTH  operand B to the adder (latched register)
//   add_z    in   WIDTH  adder sum, combinational, add_z = add_a + add_b mod 2^WIDTH
//   busy     out  1      high in every state except IDLE
//   done     out  1      1-cycle pulse when a run completes
//   ovf      out  1      sticky unsigned carry-out; cleared by an accepted start
// BEHAVIOUR
//   Reset: state = IDLE; all x[i], op_a, op_b, result and remaining cleared to 0;
//     busy, done and ovf are 0.
//   Reset mid-run aborts immediately. No partial write survives, because the file is cleared.
//   FSM: IDLE -> READ -> EXEC -> WRITE -> (READ | DONE) -> IDLE.
//   IDLE: if start, latch rd/rs1/rs2/count and clear ovf.
//     count == 0 -> DONE (no adder use, no write); else remaining <= count and go to READ.
//   READ: op_a <= x[rs1], op_b <= x[rs2]. Sees any host load committed on the start edge.
//   EXEC: result <= add_z. If add_z < op_a (unsigned), ovf <= 1.
//   WRITE: x[rd] <= result and x[rs2] <= result on the same edge.
//     rd == rs2 gives a single write.
//     remaining <= remaining - 1; go to DONE if it reaches 0, else READ.
//   DONE: done = 1 for exactly one cycle, then go to IDLE. busy stays 1 in DONE.
//   Latency: start accepted at edge E0; done is high in the cycle after edge E(3N).
//     The final writes land at E(3N). For count = 0, done is high in the cycle after E0.
//   rs1 == rd or rs1 == rs2 is legal: each iteration reads post-write values.
//   start while busy is ignored, with no queuing.
//   ld_en while busy is dropped.
//   ld_en and start on the same IDLE edge: the load commits first and the run uses the new value.
//   Sums wrap mod 2^WIDTH; ovf records only that a wrap occurred.
//   count = 255 is legal: 765 cycles plus DONE.
// TESTING
//   1. Load x6 = 1, x7 = 10; start rd = 5, rs1 = 6, rs2 = 7, count = 3.
//      -> x5 = 13, x7 = 13, ovf = 0; done in the cycle after E9; busy high from E0 to E10.
//   2. Load x1 = 32'hFFFFFFFF, x2 = 1; start rd = 3, rs1 = 1, rs2 = 2, count = 1.
//      -> x3 = 0, x2 = 0, ovf = 1. A following count = 1 run on x4 = 2, x5 = 3 clears ovf to 0.
//   3. start with count = 0 -> done pulses in the cycle after E0; no register changes.
//   4. During a busy run: ld_en to x6 = 99 and a second start.
//      -> both ignored; final results match scenario 1; exactly one done pulse.
//   5. Assert reset asynchronously at E4 of scenario 1.
//      -> busy, done, ovf = 0 immediately; rd_data = 0 for all addresses; next start works normally.
//   6. rd == rs2 == 7, rs1 = 6, x6 = 2, x7 = 3, count = 2 -> x7 = 7; done in the cycle after E6.

Source files
------------

// File: rtl/add_sequencer_if.sv
// Host and adder signal bundle for add_sequencer.
// The slave side is the sequencer; the master side is the host plus the external adder.
interface add_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             start;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [7:0]       count;
    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_z;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, rd, rs1, rs2, count,
        output ld_en, ld_addr, ld_data, rd_addr,
        output add_z,
        input  rd_data, add_a, add_b, busy, done, ovf
    );

    modport slave (
        input  start, rd, rs1, rs2, count,
        input  ld_en, ld_addr, ld_data, rd_addr,
        input  add_z,
        output rd_data, add_a, add_b, busy, done, ovf
    );
endinterface

// File: rtl/add_sequencer.sv
// Register file plus sequencer driving an external adder through the
// feedback loop x[rd] = x[rs1] + x[rs2]; x[rs2] = x[rd], COUNT times per run.
module add_sequencer #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    parameter int AW    = 5
) (
    input logic           clk,
    input logic           reset,
    add_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WRITE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q [NREG];
    logic [WIDTH-1:0] x_d [NREG];
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [7:0]       remaining_q, remaining_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW-1:0]    rs1_q, rs1_d;
    logic [AW-1:0]    rs2_q, rs2_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        result_d    = result_q;
        remaining_d = remaining_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                // Host load lands on the same edge as start, so READ sees it.
                if (bus.ld_en) begin
                    x_d[bus.ld_addr] = bus.ld_data;
                end
                if (bus.start) begin
                    rd_d  = bus.rd;
                    rs1_d = bus.rs1;
                    rs2_d = bus.rs2;
                    ovf_d = 1'b0;
                    if (bus.count == 8'd0) begin
                        state_d = S_DONE;
                    end else begin
                        remaining_d = bus.count;
                        state_d     = S_READ;
                    end
                end
            end
            S_READ: begin
                op_a_d  = x_q[rs1_q];
                op_b_d  = x_q[rs2_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = bus.add_z;
                // A wrapped unsigned sum is smaller than either operand.
                if (bus.add_z < op_a_q) begin
                    ovf_d = 1'b1;
                end
                state_d = S_WRITE;
            end
            S_WRITE: begin
                x_d[rd_q]   = result_q;
                x_d[rs2_q]  = result_q;
                remaining_d = remaining_q - 8'd1;
                if (remaining_q == 8'd1) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            remaining_q <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            result_q    <= result_d;
            remaining_q <= remaining_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < NREG; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    assign bus.rd_data = x_q[bus.rd_addr];
    assign bus.add_a   = op_a_q;
    assign bus.add_b   = op_b_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_add_sequencer.sv
// Directed bench for add_sequencer with a behavioural adder on add_a/add_b.
// Edge E0 is the edge that accepts start; edge indices below count from it.
module tb_add_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    add_sequencer_if #(.WIDTH(32), .AW(5)) bus ();

    add_sequencer #(.WIDTH(32), .NREG(32), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.add_z = bus.add_a + bus.add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.rd      = '0;
        bus.rs1     = '0;
        bus.rs2     = '0;
        bus.count   = '0;
        bus.ld_en   = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        bus.rd_addr = '0;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        @(posedge clk);
        #1;
        bus.ld_en = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
        bus.rd_addr = a;
        #1;
        d = bus.rd_data;
    endtask

    // Launches a run and watches done; disturb injects a load and a start mid-run.
    task automatic run(input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [7:0] cnt,
                       input bit disturb,
                       output int done_edge, output int pulses,
                       output logic busy_e0, output logic busy_dn,
                       output logic busy_af);
        int e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.rd    = rd;
        bus.rs1   = rs1;
        bus.rs2   = rs2;
        bus.count = cnt;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_e0   = bus.busy;
        busy_dn   = 1'b0;
        busy_af   = 1'b1;
        done_edge = -1;
        pulses    = 0;
        e = 0;
        while (e < 2000) begin
            if (disturb && e == 2) begin
                bus.ld_en   = 1'b1;
                bus.ld_addr = 5'd6;
                bus.ld_data = 32'd99;
                bus.start   = 1'b1;
                bus.rd      = 5'd9;
                bus.count   = 8'd7;
            end
            if (disturb && e == 4) begin
                bus.ld_en = 1'b0;
                bus.start = 1'b0;
            end
            if (bus.done) begin
                pulses++;
                if (done_edge < 0) begin
                    done_edge = e;
                    busy_dn   = bus.busy;
                end
            end
            if (done_edge >= 0 && e == done_edge + 1) busy_af = bus.busy;
            if (done_edge >= 0 && e >= done_edge + 4) break;
            @(posedge clk);
            #1;
            e++;
        end
        bus.ld_en = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        nz;
        reset = 1'b1;
        idle_inputs();
        #12;
        nz = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_reg(i[4:0], v);
            if (v !== 32'd0) nz = 1'b1;
        end
        checks++;
        if (nz !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: nonzero=%b required 0", nz);
        end
        checks++;
        if ({bus.busy, bus.done, bus.ovf} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: busy/done/ovf=%b required 000",
                     {bus.busy, bus.done, bus.ovf});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_accumulate();
        int de, np;
        logic b0, bd, ba;
        logic [31:0] v5, v6, v7;
        load(5'd6, 32'd1);
        load(5'd7, 32'd10);
        run(5'd5, 5'd6, 5'd7, 8'd3, 1'b0, de, np, b0, bd, ba);
        read_reg(5'd5, v5);
        read_reg(5'd6, v6);
        read_reg(5'd7, v7);
        checks++;
        if (de !== 9) begin
            failures++;
            $display("FAIL acc_latency: done edge %0d required 9", de);
        end
        checks++;
        if (np !== 1) begin
            failures++;
            $display("FAIL acc_pulses: %0d required 1", np);
        end
        checks++;
        if ({b0, bd, ba} !== 3'b110) begin
            failures++;
            $display("FAIL acc_busy: e0/done/after=%b required 110", {b0, bd, ba});
        end
        checks++;
        if ({v5, v6, v7} !== {32'd13, 32'd1, 32'd13}) begin
            failures++;
            $display("FAIL acc_regs: x5=%0d x6=%0d x7=%0d required 13 1 13",
                     v5, v6, v7);
        end
        checks++;
        if (bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL acc_ovf: %b required 0", bus.ovf);
        end
    endtask

    task automatic test_overflow();
        int de, np;
        logic b0, bd, ba;
        logic [31:0] v2, v3, v5, v6;
        load(5'd1, 32'hFFFF_FFFF);
        load(5'd2, 32'd1);
        run(5'd3, 5'd1, 5'd2, 8'd1, 1'b0, de, np, b0, bd, ba);
        read_reg(5'd2, v2);
        read_reg(5'd3, v3);
        checks++;
        if ({v3, v2} !== 64'd0) begin
            failures++;
            $display("FAIL ovf_regs: x3=%h x2=%h required 0 0", v3, v2);
        end
        checks++;
        if (bus.ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: %b required 1", bus.ovf);
        end
        checks++;
        if (de !== 3) begin
            failures++;
            $display("FAIL ovf_latency: done edge %0d required 3", de);
        end
        load(5'd4, 32'd2);
        load(5'd5, 32'd3);
        run(5'd6, 5'd4, 5'd5, 8'd1, 1'b0, de, np, b0, bd, ba);
        read_reg(5'd5, v5);
        read_reg(5'd6, v6);
        checks++;
        if ({bus.ovf, v6, v5} !== {1'b0, 32'd5, 32'd5}) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b x6=%0d x5=%0d required 0 5 5",
                     bus.ovf, v6, v5);
        end
    endtask

    task automatic test_count_zero();
        int de, np;
        logic b0, bd, ba;
        logic [31:0] v1, v4, v5, v6;
        load(5'd2, 32'd1);
        run(5'd3, 5'd1, 5'd2, 8'd1, 1'b0, de, np, b0, bd, ba);
        run(5'd6, 5'd4, 5'd5, 8'd0, 1'b0, de, np, b0, bd, ba);
        read_reg(5'd1, v1);
        read_reg(5'd4, v4);
        read_reg(5'd5, v5);
        read_reg(5'd6, v6);
        checks++;
        if (de !== 0 || np !== 1) begin
            failures++;
            $display("FAIL zero_done: edge %0d pulses %0d required 0 1", de, np);
        end
        checks++;
        if ({v1, v4, v5, v6} !== {32'hFFFF_FFFF, 32'd2, 32'd5, 32'd5}) begin
            failures++;
            $display("FAIL zero_regs: x1=%h x4=%0d x5=%0d x6=%0d required ffffffff 2 5 5",
                     v1, v4, v5, v6);
        end
        checks++;
        if (bus.ovf !== 1'b0) begin
            failures++;
            $display("FAIL zero_ovf_clear: %b required 0", bus.ovf);
        end
    endtask

    task automatic test_busy_ignore();
        int de, np;
        logic b0, bd, ba;
        logic [31:0] v5, v6, v7, v9;
        load(5'd5, 32'd0);
        load(5'd6, 32'd1);
        load(5'd7, 32'd10);
        load(5'd9, 32'd0);
        run(5'd5, 5'd6, 5'd7, 8'd3, 1'b1, de, np, b0, bd, ba);
        read_reg(5'd5, v5);
        read_reg(5'd6, v6);
        read_reg(5'd7, v7);
        read_reg(5'd9, v9);
        checks++;
        if ({v5, v6, v7, v9} !== {32'd13, 32'd1, 32'd13, 32'd0}) begin
            failures++;
            $display("FAIL busy_regs: x5=%0d x6=%0d x7=%0d x9=%0d required 13 1 13 0",
                     v5, v6, v7, v9);
        end
        checks++;
        if (de !== 9 || np !== 1) begin
            failures++;
            $display("FAIL busy_done: edge %0d pulses %0d required 9 1", de, np);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_no_queue: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_rd_eq_rs2();
        int de, np;
        logic b0, bd, ba;
        logic [31:0] v6, v7;
        load(5'd6, 32'd2);
        load(5'd7, 32'd3);
        run(5'd7, 5'd6, 5'd7, 8'd2, 1'b0, de, np, b0, bd, ba);
        read_reg(5'd6, v6);
        read_reg(5'd7, v7);
        checks++;
        if ({v6, v7} !== {32'd2, 32'd7}) begin
            failures++;
            $display("FAIL same_regs: x6=%0d x7=%0d required 2 7", v6, v7);
        end
        checks++;
        if (de !== 6) begin
            failures++;
            $display("FAIL same_latency: done edge %0d required 6", de);
        end
    endtask

    task automatic test_reset_midrun();
        int de, np;
        logic b0, bd, ba;
        logic [31:0] v, v5, v7;
        logic nz;
        load(5'd6, 32'd1);
        load(5'd7, 32'd10);
        @(negedge clk);
        bus.start = 1'b1;
        bus.rd    = 5'd5;
        bus.rs1   = 5'd6;
        bus.rs2   = 5'd7;
        bus.count = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.ovf} !== 3'b000) begin
            failures++;
            $display("FAIL midrun_flags: busy/done/ovf=%b required 000",
                     {bus.busy, bus.done, bus.ovf});
        end
        nz = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_reg(i[4:0], v);
            if (v !== 32'd0) nz = 1'b1;
        end
        checks++;
        if (nz !== 1'b0) begin
            failures++;
            $display("FAIL midrun_regs: nonzero=%b required 0", nz);
        end
        @(negedge clk);
        reset = 1'b0;
        load(5'd6, 32'd1);
        load(5'd7, 32'd10);
        run(5'd5, 5'd6, 5'd7, 8'd3, 1'b0, de, np, b0, bd, ba);
        read_reg(5'd5, v5);
        read_reg(5'd7, v7);
        checks++;
        if ({v5, v7} !== {32'd13, 32'd13} || de !== 9) begin
            failures++;
            $display("FAIL midrun_rerun: x5=%0d x7=%0d edge %0d required 13 13 9",
                     v5, v7, de);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_accumulate();
        test_overflow();
        test_count_zero();
        test_busy_ignore();
        test_rd_eq_rs2();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
